int_decl_gen: RTL

INT_DECL_GEN -- requirements
Module: int_decl_gen

---
 rtl/int_decl_gen.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/int_decl_gen.sv
// int_decl_gen
// ------------
// Emits a C-style integer declaration as a byte stream:
//    "int" ' ' id0 { ',' ' ' idk } ';'
// The identifier bytes come from an upstream valid/ready source. They are
// validated one at a time before they are emitted.
// A declaration is aborted (err pulse, back to IDLE) in three cases:
//   - a byte is illegal at its position,
//   - an identifier reaches a 32nd byte,
//   - an identifier is exactly "int".
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        begin a declaration (honoured in IDLE only)
//   num_ids[2:0] identifier count, sampled at start (0 counts as 1)
//   id_char[7:0] upstream identifier byte
//   id_valid     id_char is valid
//   id_last      id_char is the last byte of the current identifier
//   id_ready     upstream byte is consumed on this edge when id_valid is high
//   out_char     registered output byte
//   out_valid    registered output valid
//   out_ready    downstream accepts out_char
//   busy         state is not IDLE
//   done         ';' is being accepted downstream this cycle
//   err          the current upstream byte aborts the declaration
//   dbg_state_o  current FSM state (debug visibility)
//
// Handshake: a byte moves on a rising edge where valid && ready are both
// high. The source keeps data stable while valid is high and ready is low.
// out_valid never drops without a transfer, except on abort or reset.
// id_ready does not depend on id_valid.

module int_decl_gen (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] num_ids,
   input  logic [7:0] id_char,
   input  logic       id_valid,
   input  logic       id_last,
   output logic       id_ready,
   output logic [7:0] out_char,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] dbg_state_o
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_KW_I   = 4'd1,
      ST_KW_N   = 4'd2,
      ST_KW_T   = 4'd3,
      ST_SP     = 4'd4,
      ST_ID     = 4'd5,
      ST_COMMA  = 4'd6,
      ST_SEP_SP = 4'd7,
      ST_SEMI   = 4'd8
   } state_t;

   localparam logic [7:0] CH_I     = 8'h69;  // 'i'
   localparam logic [7:0] CH_N     = 8'h6e;  // 'n'
   localparam logic [7:0] CH_T     = 8'h74;  // 't'
   localparam logic [7:0] CH_SP    = 8'h20;  // ' '
   localparam logic [7:0] CH_COMMA = 8'h2c;  // ','
   localparam logic [7:0] CH_SEMI  = 8'h3b;  // ';'

   state_t     state_q, state_d;
   logic [7:0] out_char_q, out_char_d;
   logic       out_valid_q, out_valid_d;
   logic [2:0] rem_q, rem_d;   // identifiers still to come, including the current one
   logic [4:0] len_q, len_d;   // bytes already accepted in the current identifier
   logic       kw_q, kw_d;     // bytes so far are a prefix of "int"

   logic       free;
   logic       id_acc;
   logic       is_upper, is_lower, is_digit, is_us;
   logic       char_ok, too_long;
   logic [7:0] kw_char;
   logic       kw_prefix, kw_next, kw_hit;
   logic       id_bad;
   logic       semi_held;

   // The output register can take a new byte when it is empty or draining.
   assign free   = !out_valid_q || out_ready;
   assign id_acc = (state_q == ST_ID) && free && id_valid;

   // Identifier byte classification
   assign is_upper = (id_char >= 8'h41) && (id_char <= 8'h5a);
   assign is_lower = (id_char >= 8'h61) && (id_char <= 8'h7a);
   assign is_digit = (id_char >= 8'h30) && (id_char <= 8'h39);
   assign is_us    = (id_char == 8'h5f);
   assign char_ok  = is_upper || is_lower || is_us || ((len_q != 5'd0) && is_digit);
   // len_q == 31 means this byte would be the 32nd one.
   assign too_long = (len_q == 5'd31);

   always_comb begin
      kw_char = 8'h00;
      case (len_q)
         5'd0:    kw_char = CH_I;
         5'd1:    kw_char = CH_N;
         5'd2:    kw_char = CH_T;
         default: kw_char = 8'h00;
      endcase
   end

   // An empty identifier trivially matches the empty prefix of "int".
   assign kw_prefix = (len_q == 5'd0) || kw_q;
   assign kw_next   = kw_prefix && (len_q < 5'd3) && (id_char == kw_char);
   // The keyword match only counts when the identifier ends on its 3rd byte.
   assign kw_hit    = id_last && (len_q == 5'd2) && kw_next;
   assign id_bad    = !char_ok || too_long || kw_hit;

   // In SEMI the register holds either the final identifier byte or ';'.
   // An identifier byte can never be ';', so the byte value tells them apart.
   assign semi_held = out_valid_q && (out_char_q == CH_SEMI);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_KW_I;
         ST_KW_I:   if (free)  state_d = ST_KW_N;
         ST_KW_N:   if (free)  state_d = ST_KW_T;
         ST_KW_T:   if (free)  state_d = ST_SP;
         ST_SP:     if (free)  state_d = ST_ID;
         ST_ID: begin
            if (id_acc) begin
               if (id_bad)                 state_d = ST_IDLE;
               else if (id_last)           state_d = (rem_q == 3'd1) ? ST_SEMI : ST_COMMA;
            end
         end
         ST_COMMA:  if (free)  state_d = ST_SEP_SP;
         ST_SEP_SP: if (free)  state_d = ST_ID;
         ST_SEMI:   if (semi_held && out_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      out_char_d  = out_char_q;
      out_valid_d = out_valid_q;
      rem_d       = rem_q;
      len_d       = len_q;
      kw_d        = kw_q;
      // A free register with nothing new to load becomes empty.
      if (free) out_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rem_d = (num_ids == 3'd0) ? 3'd1 : num_ids;
               len_d = 5'd0;
               kw_d  = 1'b0;
            end
         end
         ST_KW_I:   if (free) begin out_char_d = CH_I;     out_valid_d = 1'b1; end
         ST_KW_N:   if (free) begin out_char_d = CH_N;     out_valid_d = 1'b1; end
         ST_KW_T:   if (free) begin out_char_d = CH_T;     out_valid_d = 1'b1; end
         ST_SP:     if (free) begin out_char_d = CH_SP;    out_valid_d = 1'b1; end
         ST_COMMA:  if (free) begin out_char_d = CH_COMMA; out_valid_d = 1'b1; end
         ST_SEP_SP: if (free) begin out_char_d = CH_SP;    out_valid_d = 1'b1; end
         ST_ID: begin
            if (id_acc) begin
               if (id_bad) begin
                  // The offending byte is dropped and the declaration abandoned.
                  out_valid_d = 1'b0;
                  rem_d       = 3'd0;
                  len_d       = 5'd0;
                  kw_d        = 1'b0;
               end else begin
                  out_char_d  = id_char;
                  out_valid_d = 1'b1;
                  if (id_last) begin
                     rem_d = rem_q - 3'd1;
                     len_d = 5'd0;
                     kw_d  = 1'b0;
                  end else begin
                     len_d = len_q + 5'd1;
                     kw_d  = kw_next;
                  end
               end
            end
         end
         ST_SEMI: begin
            if (free && !semi_held) begin
               out_char_d  = CH_SEMI;
               out_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         out_char_q  <= 8'h00;
         out_valid_q <= 1'b0;
         rem_q       <= 3'd0;
         len_q       <= 5'd0;
         kw_q        <= 1'b0;
      end else begin
         out_char_q  <= out_char_d;
         out_valid_q <= out_valid_d;
         rem_q       <= rem_d;
         len_q       <= len_d;
         kw_q        <= kw_d;
      end
   end

   assign id_ready    = (state_q == ST_ID) && free;
   assign out_char    = out_char_q;
   assign out_valid   = out_valid_q;
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_SEMI) && semi_held && out_ready;
   assign err         = id_acc && id_bad;
   assign dbg_state_o = state_q;

endmodule
